immu_tlb_walker: RTL and testbench
==================================

# immu_tlb_walker

Sequential lookup front-end for the instruction MMU. It accepts one fetch-translation request at a time and scans the TLB entry array one entry per cycle through a registered read port. Each returned entry goes through the IMMU hit/permission judge, and the block returns one of three results: a physical address, an ISI exception, or an ITLB-miss exception. It sits between the fetch unit and the TLB array, directly upstream of the hit-judge logic.

## Interface
- ENTRIES, 16, number of TLB entries scanned (power of two, 2..64)
- IDX_W, 4, index width, equal to log2(ENTRIES)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Req_Valid  in  1  translation request present
- Req_Ready  out  1  high only in IDLE
- EA  in  32  effective address; EA[31:12] is the EPN and EA[11:0] is the page offset
- AS, MSR_PR  in  1 each  address space and privilege level, sampled at accept
- PID0, PID1, PID2  in  8 each  process IDs, sampled at accept
- TLB_Rd_En  out  1  read strobe to the TLB array
- TLB_Rd_Idx  out  IDX_W  entry index being read
- TLB_entry_V, TLB_entry_TS  in  1 each  entry fields; valid the cycle after TLB_Rd_En
- TLB_entry_TID  in  8; TLB_entry_EPN  in  20; TLB_entry_RPN  in  20; TLB_entry_PERMIS  in  6 (SR,UR,SW,UW,SX,UX)
- Flush  in  1  abort the current request
- Resp_Valid  out  1  result available
- Resp_Ready  in  1  consumer accepts the result
- Resp_PA  out  32  physical address
- Resp_Exception  out  5  exception code: 0, `ISI or `ITLB
- Resp_Idx  out  IDX_W  index of the deciding entry

## Operation
- **States:** IDLE, SCAN, DONE.
- **Reset:** state IDLE, Req_Ready=1, TLB_Rd_En=0, TLB_Rd_Idx=0, Resp_Valid=0, Resp_PA=0, Resp_Exception=0, Resp_Idx=0, all latched request fields 0.
- **IDLE:** when Req_Valid=1, the block latches EA, AS, MSR_PR and PID0-2, then moves to SCAN. Req_Ready is 0 in every state except IDLE.
- **SCAN issue side:** TLB_Rd_En=1 with TLB_Rd_Idx = i, where i counts 0..ENTRIES-1, one index per cycle. No read is issued beyond ENTRIES-1.
- **SCAN evaluate side:** the entry returned for index i-1 is evaluated in the same cycle that index i is issued.
  - Match = V && (TS==AS) && (TID==0 or TID equals PID0, PID1 or PID2) && (EPN==EA[31:12]).
  - Permission is UX when MSR_PR=1 and SX when MSR_PR=0.
- **First match decides. The lowest index wins and the scan stops:**
  - Match with permission: Resp_PA = {RPN, EA[11:0]}, Resp_Exception = 0, Resp_Idx = the entry index.
  - Match without permission: Resp_PA = 0, Resp_Exception = `ISI, Resp_Idx = the entry index.
  - Non-matching entries with missing permission produce no exception and the scan continues.
- **Miss:** if no entry 0..ENTRIES-1 matches, Resp_Exception = `ITLB, Resp_PA = 0, Resp_Idx = 0.
- **Outstanding read:** when a match is found on index k, the read already issued for k+1 is ignored.
- **DONE:** Resp_Valid=1 and all response fields are held stable. When Resp_Ready=1, the block returns to IDLE and clears Resp_Valid on that edge.
- **Flush:** any state goes to IDLE on the next edge. Resp_Valid, TLB_Rd_En and the scan counter clear, and no response is produced for the aborted request. Flush has priority over Req_Valid and Resp_Ready in the same cycle.
- **Exception codes:** `ISI and `ITLB are 5-bit values taken from the shared MMU define file.

## Timing
- Accept edge E0, i.e. the edge with Req_Valid=1 in IDLE.
- Index k is issued in the cycle after edge E(k).
- Entry data for index k is evaluated in the cycle after edge E(k+1).
- **Hit or ISI on entry k:** Resp_Valid=1 from edge E(k+2). Latency is k+2 cycles, minimum 2.
- **Miss:** Resp_Valid=1 from edge E(ENTRIES+1), which is 17 cycles at the default ENTRIES.
- **Back-to-back requests:** a Resp_Ready edge returns the block to IDLE, and the next request is accepted no earlier than the following edge. Maximum throughput is one request per k+4 cycles.
- **Reset mid-scan:** asserting rst_n low forces the reset values immediately (asynchronous), and any partial result is lost.
- Resp_Ready held low keeps DONE indefinitely with outputs stable.

## Test plan
- **Hit:** entry 0 = {V=1, TS=0, TID=0, EPN=0x12345, RPN=0xABCDE, PERMIS=6'b000001}; request EA=0x12345678, AS=0, MSR_PR=1, Resp_Ready=1. Required: Resp_Valid at E2, Resp_PA=0xABCDE678, Resp_Exception=0, Resp_Idx=0.
- **ISI:** entry 5 matches with TID=0x07, PID1=0x07, PERMIS=6'b000001, MSR_PR=0. Required: Resp_Valid at E7, Resp_Exception=`ISI, Resp_PA=0, Resp_Idx=5, and exactly 6 reads issued (indices 0..5) plus one extra issued read (index 6) that is ignored.
- **Miss with permission-less non-matching entries:** all entries V=0 except entry 3 {V=1, EPN=0x00001, PERMIS=0}; EA=0x00002000. Required: Resp_Valid at E17, Resp_Exception=`ITLB, TLB_Rd_Idx sweeps 0..15 exactly once.
- **Duplicate match:** entries 2 and 9 both match, with RPN 0x11111 and 0x22222. Required: Resp_PA={0x11111, offset}, Resp_Idx=2.
- **Flush and backpressure:** Flush at cycle 4 of a scan gives Req_Ready=1 on the next cycle and no Resp_Valid. Then a new request that hits with Resp_Ready=0 for 10 cycles gives Resp_Valid and Resp_PA stable for all 10 cycles, and Req_Ready=0 for all 10 cycles.
- **Reset mid-scan:** rst_n=0 mid-scan gives all outputs at their reset values within the same cycle. After release, a fresh request completes normally.

Source files
------------

// File: rtl/immu_tlb_walker.sv
// Instruction-MMU TLB walker: scans TLB entries one per cycle and judges hit/permission on the first match.
// Latency k+2 cycles for a decision on entry k, ENTRIES+1 on a miss; DONE holds the result until Resp_Ready.

// Fallback exception codes when the shared MMU define file has not been included ahead of this file.
`ifndef ISI
`define ISI 5'd3
`endif
`ifndef ITLB
`define ITLB 5'd14
`endif

module immu_tlb_walker #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [31:0]      EA,
  input  logic             AS,
  input  logic             MSR_PR,
  input  logic [7:0]       PID0,
  input  logic [7:0]       PID1,
  input  logic [7:0]       PID2,
  output logic             TLB_Rd_En,
  output logic [IDX_W-1:0] TLB_Rd_Idx,
  input  logic             TLB_entry_V,
  input  logic             TLB_entry_TS,
  input  logic [7:0]       TLB_entry_TID,
  input  logic [19:0]      TLB_entry_EPN,
  input  logic [19:0]      TLB_entry_RPN,
  input  logic [5:0]       TLB_entry_PERMIS,
  input  logic             Flush,
  output logic             Resp_Valid,
  input  logic             Resp_Ready,
  output logic [31:0]      Resp_PA,
  output logic [4:0]       Resp_Exception,
  output logic [IDX_W-1:0] Resp_Idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  // One extra bit: cnt == ENTRIES marks "all reads issued, last entry under evaluation".
  logic [IDX_W:0]   cnt, cnt_nxt;
  logic [31:0]      ea_q;
  logic             as_q, pr_q;
  logic [7:0]       pid0_q, pid1_q, pid2_q;
  logic [31:0]      pa_q, pa_nxt;
  logic [4:0]       exc_q, exc_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;

  logic             accept;
  logic             eval_vld;
  logic [IDX_W-1:0] eval_idx;
  logic             tid_ok, match, perm_ok;
  logic             unused_perm;

  // Only the execute bits (SX, UX) matter for instruction fetch.
  assign unused_perm = ^TLB_entry_PERMIS[5:2];

  assign accept   = (state == IDLE) && Req_Valid && !Flush;
  assign eval_vld = (state == SCAN) && (cnt != '0);
  assign eval_idx = IDX_W'(cnt - 1'b1);

  assign tid_ok  = (TLB_entry_TID == 8'd0) || (TLB_entry_TID == pid0_q) ||
                   (TLB_entry_TID == pid1_q) || (TLB_entry_TID == pid2_q);
  assign match   = TLB_entry_V && (TLB_entry_TS == as_q) && tid_ok &&
                   (TLB_entry_EPN == ea_q[31:12]);
  assign perm_ok = pr_q ? TLB_entry_PERMIS[0] : TLB_entry_PERMIS[1];

  assign Req_Ready      = (state == IDLE);
  assign TLB_Rd_En      = (state == SCAN) && !cnt[IDX_W];
  assign TLB_Rd_Idx     = TLB_Rd_En ? cnt[IDX_W-1:0] : '0;
  assign Resp_Valid     = (state == DONE);
  assign Resp_PA        = pa_q;
  assign Resp_Exception = exc_q;
  assign Resp_Idx       = idx_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pa_nxt    = pa_q;
    exc_nxt   = exc_q;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (Req_Valid) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      end
      SCAN: begin
        if (eval_vld && match) begin
          state_nxt = DONE;
          idx_nxt   = eval_idx;
          if (perm_ok) begin
            pa_nxt  = {TLB_entry_RPN, ea_q[11:0]};
            exc_nxt = 5'd0;
          end else begin
            pa_nxt  = 32'd0;
            exc_nxt = `ISI;
          end
        end else if (cnt[IDX_W]) begin
          state_nxt = DONE;
          pa_nxt    = 32'd0;
          exc_nxt   = `ITLB;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (Resp_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (Flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pa_q   <= 32'd0;
      exc_q  <= 5'd0;
      idx_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pa_q   <= pa_nxt;
      exc_q  <= exc_nxt;
      idx_q  <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q   <= 32'd0;
      as_q   <= 1'b0;
      pr_q   <= 1'b0;
      pid0_q <= 8'd0;
      pid1_q <= 8'd0;
      pid2_q <= 8'd0;
    end else if (accept) begin
      ea_q   <= EA;
      as_q   <= AS;
      pr_q   <= MSR_PR;
      pid0_q <= PID0;
      pid1_q <= PID1;
      pid2_q <= PID2;
    end
  end

endmodule

// File: tb/tb_immu_tlb_walker.sv
// Bench for immu_tlb_walker: registered TLB array model, timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requests with flushes and backpressure.

`ifndef ISI
`define ISI 5'd3
`endif
`ifndef ITLB
`define ITLB 5'd14
`endif

module tb_immu_tlb_walker;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Req_Valid, Req_Ready;
  logic [31:0]      EA;
  logic             AS, MSR_PR;
  logic [7:0]       PID0, PID1, PID2;
  logic             TLB_Rd_En;
  logic [IDX_W-1:0] TLB_Rd_Idx;
  logic             TLB_entry_V, TLB_entry_TS;
  logic [7:0]       TLB_entry_TID;
  logic [19:0]      TLB_entry_EPN, TLB_entry_RPN;
  logic [5:0]       TLB_entry_PERMIS;
  logic             Flush;
  logic             Resp_Valid, Resp_Ready;
  logic [31:0]      Resp_PA;
  logic [4:0]       Resp_Exception;
  logic [IDX_W-1:0] Resp_Idx;

  immu_tlb_walker #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .EA(EA), .AS(AS), .MSR_PR(MSR_PR), .PID0(PID0), .PID1(PID1), .PID2(PID2),
    .TLB_Rd_En(TLB_Rd_En), .TLB_Rd_Idx(TLB_Rd_Idx),
    .TLB_entry_V(TLB_entry_V), .TLB_entry_TS(TLB_entry_TS), .TLB_entry_TID(TLB_entry_TID),
    .TLB_entry_EPN(TLB_entry_EPN), .TLB_entry_RPN(TLB_entry_RPN), .TLB_entry_PERMIS(TLB_entry_PERMIS),
    .Flush(Flush), .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
    .Resp_PA(Resp_PA), .Resp_Exception(Resp_Exception), .Resp_Idx(Resp_Idx)
  );

  always #5 clk = ~clk;

  // TLB contents, only modified while the walker is idle.
  logic        tv   [ENTRIES];
  logic        tts  [ENTRIES];
  logic [7:0]  ttid [ENTRIES];
  logic [19:0] tepn [ENTRIES];
  logic [19:0] trpn [ENTRIES];
  logic [5:0]  tperm[ENTRIES];

  // Registered read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (TLB_Rd_En) begin
      TLB_entry_V      <= tv[TLB_Rd_Idx];
      TLB_entry_TS     <= tts[TLB_Rd_Idx];
      TLB_entry_TID    <= ttid[TLB_Rd_Idx];
      TLB_entry_EPN    <= tepn[TLB_Rd_Idx];
      TLB_entry_RPN    <= trpn[TLB_Rd_Idx];
      TLB_entry_PERMIS <= tperm[TLB_Rd_Idx];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first matching entry decides; latency is its index + 2, a miss takes ENTRIES + 1.
  task automatic model(input logic [31:0] ea, input logic as, input logic pr,
                       input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                       output logic [31:0] pa, output logic [4:0] exc, output int idx, output int lat);
    pa = 32'd0; exc = `ITLB; idx = 0; lat = ENTRIES + 1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tv[i] && tts[i] == as && (ttid[i] == 0 || ttid[i] == p0 || ttid[i] == p1 || ttid[i] == p2)
          && tepn[i] == ea[31:12]) begin
        idx = i;
        lat = i + 2;
        if (pr ? tperm[i][0] : tperm[i][1]) begin
          pa = {trpn[i], ea[11:0]}; exc = 5'd0;
        end else begin
          pa = 32'd0; exc = `ISI;
        end
        break;
      end
    end
  endtask

  // Timeline model: phase 0 idle, 1 busy; n = edges since the accept edge.
  int          m_phase = 0, m_n = 0, m_lat = 0, m_idx = 0;
  logic [31:0] m_pa = 0;
  logic [4:0]  m_exc = 0;
  int          obs_lat = 0, obs_reads = 0, obs_idx = 0;
  logic        obs_seen = 0;
  logic [31:0] obs_pa = 0;
  logic [4:0]  obs_exc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", Req_Ready, 1);
      chk("rst_rd_en", TLB_Rd_En, 0);
      chk("rst_rd_idx", TLB_Rd_Idx, 0);
      chk("rst_resp_valid", Resp_Valid, 0);
      chk("rst_resp_pa", Resp_PA, 0);
      chk("rst_resp_exc", Resp_Exception, 0);
      chk("rst_resp_idx", Resp_Idx, 0);
      m_phase = 0;
    end else begin
      logic exp_rd, exp_vld;
      exp_rd  = (m_phase == 1) && (m_n < m_lat) && (m_n < ENTRIES);
      exp_vld = (m_phase == 1) && (m_n >= m_lat);
      chk("req_ready", Req_Ready, m_phase == 0);
      chk("resp_valid", Resp_Valid, exp_vld);
      chk("rd_en", TLB_Rd_En, exp_rd);
      if (exp_rd) chk("rd_idx", TLB_Rd_Idx, m_n);
      if (exp_vld) begin
        chk("resp_pa", Resp_PA, m_pa);
        chk("resp_exc", Resp_Exception, m_exc);
        chk("resp_idx", Resp_Idx, m_idx);
      end
      if (m_phase == 1) begin
        if (TLB_Rd_En) obs_reads++;
        if (Resp_Valid && !obs_seen) begin
          obs_seen = 1; obs_lat = m_n; obs_pa = Resp_PA; obs_exc = Resp_Exception; obs_idx = Resp_Idx;
        end
      end
      if (Flush) m_phase = 0;
      else if (m_phase == 0 && Req_Valid) begin
        model(EA, AS, MSR_PR, PID0, PID1, PID2, m_pa, m_exc, m_idx, m_lat);
        m_phase = 1; m_n = 0; obs_reads = 0; obs_seen = 0;
      end else if (m_phase == 1) begin
        if (m_n >= m_lat && Resp_Ready) m_phase = 0;
        else m_n++;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic clear_table();
    for (int i = 0; i < ENTRIES; i++) begin
      tv[i] = 0; tts[i] = 0; ttid[i] = 0; tepn[i] = 0; trpn[i] = 0; tperm[i] = 0;
    end
  endtask

  task automatic set_entry(input int i, input logic ts, input logic [7:0] tid,
                           input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] perm);
    tv[i] = 1; tts[i] = ts; ttid[i] = tid; tepn[i] = epn; trpn[i] = rpn; tperm[i] = perm;
  endtask

  task automatic send(input logic [31:0] ea, input logic as, input logic pr,
                      input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    for (int t = 0; t < 50 && !Req_Ready; t++) tick(1);
    if (!Req_Ready) chk("req_ready_timeout", 0, 1);
    EA = ea; AS = as; MSR_PR = pr; PID0 = p0; PID1 = p1; PID2 = p2;
    Req_Valid = 1;
    tick(1);
    Req_Valid = 0;
  endtask

  task automatic wait_resp(input int hold);
    for (int t = 0; t < 60 && !Resp_Valid; t++) tick(1);
    if (!Resp_Valid) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    tick(hold);
    Resp_Ready = 1;
    tick(1);
    Resp_Ready = 0;
  endtask

  task automatic flush_pulse();
    Flush = 1;
    tick(1);
    Flush = 0;
  endtask

  initial begin
    logic [31:0] mpa;
    logic [4:0]  mexc;
    int          midx, mlat;

    rst_n = 0; Req_Valid = 0; Resp_Ready = 0; Flush = 0;
    EA = 0; AS = 0; MSR_PR = 0; PID0 = 0; PID1 = 0; PID2 = 0;
    clear_table();
    tick(3);
    rst_n = 1;
    tick(1);

    // Hit on entry 0 with user execute permission.
    set_entry(0, 0, 8'h00, 20'h12345, 20'hABCDE, 6'b000001);
    model(32'h12345678, 0, 1, 8'd0, 8'd0, 8'd0, mpa, mexc, midx, mlat);
    chk("model_hit_pa", mpa, 32'hABCDE678);
    chk("model_hit_lat", mlat, 2);
    send(32'h12345678, 0, 1, 8'd0, 8'd0, 8'd0);
    wait_resp(0);
    chk("hit_lat", obs_lat, 2);
    chk("hit_pa", obs_pa, 32'hABCDE678);
    chk("hit_exc", obs_exc, 0);
    chk("hit_idx", obs_idx, 0);

    // ISI on entry 5, matched via PID1, supervisor lacks SX.
    clear_table();
    set_entry(5, 0, 8'h07, 20'h00ABC, 20'h55555, 6'b000001);
    send(32'h00ABC010, 0, 0, 8'h01, 8'h07, 8'h02);
    wait_resp(0);
    chk("isi_lat", obs_lat, 7);
    chk("isi_exc", obs_exc, `ISI);
    chk("isi_pa", obs_pa, 0);
    chk("isi_idx", obs_idx, 5);
    chk("isi_reads", obs_reads, 7);

    // Miss, with a permission-less non-matching valid entry.
    clear_table();
    set_entry(3, 0, 8'h00, 20'h00001, 20'h0, 6'b000000);
    send(32'h00002000, 0, 1, 8'd0, 8'd0, 8'd0);
    wait_resp(0);
    chk("miss_lat", obs_lat, 17);
    chk("miss_exc", obs_exc, `ITLB);
    chk("miss_pa", obs_pa, 0);
    chk("miss_idx", obs_idx, 0);
    chk("miss_reads", obs_reads, 16);

    // Duplicate match: lowest index wins.
    clear_table();
    set_entry(2, 1, 8'h00, 20'h0BEEF, 20'h11111, 6'b000011);
    set_entry(9, 1, 8'h00, 20'h0BEEF, 20'h22222, 6'b000011);
    send(32'h0BEEFABC, 1, 0, 8'd0, 8'd0, 8'd0);
    wait_resp(0);
    chk("dup_pa", obs_pa, 32'h11111ABC);
    chk("dup_idx", obs_idx, 2);

    // Flush at cycle 4 of a scan, then a hit held under backpressure.
    send(32'h00777000, 1, 0, 8'd0, 8'd0, 8'd0);
    tick(3);
    flush_pulse();
    chk("flush_req_ready", Req_Ready, 1);
    chk("flush_resp_valid", Resp_Valid, 0);
    tick(20);
    chk("flush_no_resp", obs_seen, 0);
    send(32'h0BEEF004, 1, 0, 8'd0, 8'd0, 8'd0);
    wait_resp(10);
    chk("bp_pa", obs_pa, 32'h11111004);

    // Asynchronous reset mid-scan, then a fresh request.
    send(32'h00777000, 1, 0, 8'd0, 8'd0, 8'd0);
    tick(4);
    rst_n = 0;
    #1;
    chk("amid_req_ready", Req_Ready, 1);
    chk("amid_rd_en", TLB_Rd_En, 0);
    chk("amid_resp_valid", Resp_Valid, 0);
    tick(2);
    rst_n = 1;
    tick(1);
    send(32'h0BEEF3C0, 1, 1, 8'd0, 8'd0, 8'd0);
    wait_resp(1);
    chk("post_rst_pa", obs_pa, 32'h111113C0);
    chk("post_rst_lat", obs_lat, 4);

    // Randomized requests over small EPN/TID pools so hits, ISIs and misses all occur.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tv[i]    = ($urandom % 4) != 0;
        tts[i]   = $urandom % 2;
        ttid[i]  = ($urandom % 3 == 0) ? 8'd0 : 8'($urandom_range(1, 4));
        tepn[i]  = 20'($urandom_range(0, 5));
        trpn[i]  = 20'($urandom);
        tperm[i] = 6'($urandom);
      end
      send({20'($urandom_range(0, 6)), 12'($urandom)}, 1'($urandom), 1'($urandom),
           8'($urandom_range(1, 4)), 8'($urandom_range(1, 4)), 8'($urandom_range(5, 9)));
      if ($urandom % 5 == 0) begin
        tick($urandom_range(0, 20));
        flush_pulse();
      end else begin
        wait_resp($urandom_range(0, 3));
      end
    end
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
